// File: rtl/ce_reset_gen.sv
// ce_reset_gen: core reset sequencer and fractional clock-enable generator.
// Runs entirely on the PLL output clock. The core reset is released only after
// the synchronised PLL lock flag has been high for RST_HOLD qualifying cycles.
// CPU, sound and pixel enables come from phase accumulators (f_ce = f_clk*NUM/DEN).
module ce_reset_gen #(
    parameter int CPU_NUM  = 1,
    parameter int CPU_DEN  = 10,
    parameter int SND_NUM  = 1,
    parameter int SND_DEN  = 20,
    parameter int PIX_NUM  = 3,
    parameter int PIX_DEN  = 40,
    parameter int RST_HOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic reset_req,
    input  logic pause,
    output logic core_reset,
    output logic locked_sync,
    output logic ce_cpu,
    output logic ce_cpu_phi1,
    output logic ce_cpu_phi2,
    output logic ce_snd,
    output logic ce_pix
);

    // Rate pairs must give single-cycle pulses: 0 < NUM < DEN.
    if (CPU_NUM < 1 || CPU_NUM >= CPU_DEN) begin : g_bad_cpu
        $error("ce_reset_gen: CPU_NUM must satisfy 0 < CPU_NUM < CPU_DEN");
    end
    if (SND_NUM < 1 || SND_NUM >= SND_DEN) begin : g_bad_snd
        $error("ce_reset_gen: SND_NUM must satisfy 0 < SND_NUM < SND_DEN");
    end
    if (PIX_NUM < 1 || PIX_NUM >= PIX_DEN) begin : g_bad_pix
        $error("ce_reset_gen: PIX_NUM must satisfy 0 < PIX_NUM < PIX_DEN");
    end
    if (RST_HOLD < 2) begin : g_bad_hold
        $error("ce_reset_gen: RST_HOLD must be at least 2");
    end

    // One extra bit over clog2(DEN) so acc + NUM (< 2*DEN) never overflows.
    localparam int CPU_AW = $clog2(CPU_DEN) + 1;
    localparam int SND_AW = $clog2(SND_DEN) + 1;
    localparam int PIX_AW = $clog2(PIX_DEN) + 1;
    localparam int HW     = $clog2(RST_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);

    logic              sync1_q, sync2_q;
    logic [HW-1:0]     hold_q, hold_d;
    logic              core_reset_q, core_reset_d;

    logic [CPU_AW-1:0] cpu_acc_q, cpu_acc_d, cpu_sum;
    logic [SND_AW-1:0] snd_acc_q, snd_acc_d, snd_sum;
    logic [PIX_AW-1:0] pix_acc_q, pix_acc_d, pix_sum;
    logic              cpu_hit, snd_hit, pix_hit;

    logic              tog_q;
    logic              ce_cpu_q, phi1_q, phi2_q, ce_snd_q, ce_pix_q;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Hold counter restarts on lock loss or soft reset; release once it has saturated.
    always_comb begin
        hold_d       = hold_q;
        core_reset_d = core_reset_q;
        if (!sync2_q || reset_req) begin
            hold_d       = '0;
            core_reset_d = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
            core_reset_d = 1'b0;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Reset sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            core_reset_q <= 1'b1;
        end else begin
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
        end
    end

    // Phase accumulators: add NUM, wrap by DEN and flag a hit on each wrap.
    always_comb begin
        cpu_sum   = cpu_acc_q + CPU_AW'(CPU_NUM);
        cpu_hit   = (cpu_sum >= CPU_AW'(CPU_DEN));
        cpu_acc_d = cpu_hit ? (cpu_sum - CPU_AW'(CPU_DEN)) : cpu_sum;
        snd_sum   = snd_acc_q + SND_AW'(SND_NUM);
        snd_hit   = (snd_sum >= SND_AW'(SND_DEN));
        snd_acc_d = snd_hit ? (snd_sum - SND_AW'(SND_DEN)) : snd_sum;
        pix_sum   = pix_acc_q + PIX_AW'(PIX_NUM);
        pix_hit   = (pix_sum >= PIX_AW'(PIX_DEN));
        pix_acc_d = pix_hit ? (pix_sum - PIX_AW'(PIX_DEN)) : pix_sum;
    end

    // Accumulators keep running through core_reset and pause to preserve phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_acc_q <= '0;
            snd_acc_q <= '0;
            pix_acc_q <= '0;
        end else begin
            cpu_acc_q <= cpu_acc_d;
            snd_acc_q <= snd_acc_d;
            pix_acc_q <= pix_acc_d;
        end
    end

    // Registered enables; pause masks CPU/sound only, and the phi toggle follows unmasked CPU hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q    <= 1'b0;
            ce_cpu_q <= 1'b0;
            phi1_q   <= 1'b0;
            phi2_q   <= 1'b0;
            ce_snd_q <= 1'b0;
            ce_pix_q <= 1'b0;
        end else begin
            tog_q    <= tog_q ^ (cpu_hit & ~pause);
            ce_cpu_q <= cpu_hit & ~pause;
            phi1_q   <= cpu_hit & ~pause & ~tog_q;
            phi2_q   <= cpu_hit & ~pause & tog_q;
            ce_snd_q <= snd_hit & ~pause;
            ce_pix_q <= pix_hit;
        end
    end

    assign core_reset  = core_reset_q;
    assign locked_sync = sync2_q;
    assign ce_cpu      = ce_cpu_q;
    assign ce_cpu_phi1 = phi1_q;
    assign ce_cpu_phi2 = phi2_q;
    assign ce_snd      = ce_snd_q;
    assign ce_pix      = ce_pix_q;

endmodule

// File: tb/tb_ce_reset_gen.sv
// tb_ce_reset_gen: directed scenarios followed by randomized stimulus, checked each
// cycle against a history-based reference model of reset release and enable rates.
module tb_ce_reset_gen;

    localparam int RST_HOLD = 16;
    localparam int CPU_NUM  = 1;
    localparam int CPU_DEN  = 10;
    localparam int SND_NUM  = 1;
    localparam int SND_DEN  = 20;
    localparam int PIX_NUM  = 3;
    localparam int PIX_DEN  = 40;

    // Clock and stimulus
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst        = 1'b1;
    logic pll_locked = 1'b0;
    logic reset_req  = 1'b0;
    logic pause      = 1'b0;

    logic core_reset, locked_sync, ce_cpu, ce_cpu_phi1, ce_cpu_phi2, ce_snd, ce_pix;

    ce_reset_gen #(
        .CPU_NUM(CPU_NUM), .CPU_DEN(CPU_DEN),
        .SND_NUM(SND_NUM), .SND_DEN(SND_DEN),
        .PIX_NUM(PIX_NUM), .PIX_DEN(PIX_DEN),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .reset_req(reset_req),
        .pause(pause),
        .core_reset(core_reset),
        .locked_sync(locked_sync),
        .ce_cpu(ce_cpu),
        .ce_cpu_phi1(ce_cpu_phi1),
        .ce_cpu_phi2(ce_cpu_phi2),
        .ce_snd(ce_snd),
        .ce_pix(ce_pix)
    );

    // Counters
    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: input history, qualifying streak, run length since rst.
    bit rst_h1 = 1'b1, rst_h2 = 1'b1;
    bit pll_h1 = 1'b0, pll_h2 = 1'b0;
    bit ls_prev = 1'b0;
    int streak = 0;
    int run = 0;
    int cpu_pulses = 0;
    int n_cpu = 0, n_snd = 0, n_pix = 0;

    // A rate NUM/DEN source fires in the cycle where floor(n*NUM/DEN) steps up.
    function automatic bit crossed(int n, int num, int den);
        if (n < 1) return 1'b0;
        return ((n * num) / den) != (((n - 1) * num) / den);
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_count(string tag, int obs, int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic step();
        bit r_now, p_now, q_now, pa_now;
        bit exp_ls, exp_cr, exp_cpu, exp_snd, exp_pix, exp_p1, exp_p2;
        r_now  = rst;
        p_now  = pll_locked;
        q_now  = reset_req;
        pa_now = pause;
        @(posedge clk);
        #1;
        rst_h2 = rst_h1; rst_h1 = r_now;
        pll_h2 = pll_h1; pll_h1 = p_now;
        exp_ls = pll_h2 & ~rst_h1 & ~rst_h2;

        // core_reset is low only after RST_HOLD consecutive qualifying cycles.
        if (!r_now && ls_prev && !q_now) begin
            if (streak < RST_HOLD) streak++;
        end else begin
            streak = 0;
        end
        exp_cr  = (streak < RST_HOLD);
        ls_prev = exp_ls;

        if (r_now) run = 0;
        else       run++;
        exp_cpu = !r_now && crossed(run, CPU_NUM, CPU_DEN) && !pa_now;
        exp_snd = !r_now && crossed(run, SND_NUM, SND_DEN) && !pa_now;
        exp_pix = !r_now && crossed(run, PIX_NUM, PIX_DEN);

        if (r_now) cpu_pulses = 0;
        if (exp_cpu) cpu_pulses++;
        exp_p1 = exp_cpu && (cpu_pulses % 2 == 1);
        exp_p2 = exp_cpu && (cpu_pulses % 2 == 0);

        check("locked_sync", locked_sync, exp_ls);
        check("core_reset", core_reset, exp_cr);
        check("ce_cpu", ce_cpu, exp_cpu);
        check("ce_cpu_phi1", ce_cpu_phi1, exp_p1);
        check("ce_cpu_phi2", ce_cpu_phi2, exp_p2);
        check("ce_snd", ce_snd, exp_snd);
        check("ce_pix", ce_pix, exp_pix);

        if (ce_cpu === 1'b1) n_cpu++;
        if (ce_snd === 1'b1) n_snd++;
        if (ce_pix === 1'b1) n_pix++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // T1: reset with lock already high, then release after the hold period
        rst = 1'b1; pll_locked = 1'b1;
        steps(5);
        rst = 1'b0;
        steps(30);
        check("t1_released", core_reset, 1'b0);

        // T2: free run, rate counts over 400 cycles
        n_cpu = 0; n_snd = 0; n_pix = 0;
        steps(400);
        check_count("t2_cpu_count", n_cpu, 40);
        check_count("t2_snd_count", n_snd, 20);
        check_count("t2_pix_count", n_pix, 30);

        // T3: pause for 37 cycles, pixel enable keeps running
        n_cpu = 0; n_snd = 0; n_pix = 0;
        pause = 1'b1;
        steps(37);
        pause = 1'b0;
        check_count("t3_cpu_paused", n_cpu, 0);
        check_count("t3_snd_paused", n_snd, 0);
        steps(40);

        // T4: lock glitch while hold counter is at 8
        pll_locked = 1'b0;
        steps(3);
        pll_locked = 1'b1;
        for (int i = 0; i < 50 && streak != 8; i++) step();
        check_count("t4_reach_count8", streak, 8);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        steps(40);

        // T5: soft reset request for 3 cycles after release
        reset_req = 1'b1;
        steps(3);
        reset_req = 1'b0;
        steps(30);

        // T6: single-cycle rst mid-run
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(60);

        // Randomized operation
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) pll_locked = ~pll_locked;
            if (!pll_locked && $urandom_range(0, 19) == 0) pll_locked = 1'b1;
            if (reset_req) reset_req = ($urandom_range(0, 3) != 0);
            else           reset_req = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 24) == 0) pause = ~pause;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
